wave_dump_sequencer: RTL
========================

WAVE_DUMP_SEQUENCER -- requirements
Module: wave_dump_sequencer

Interface
REQ-001 Parameter BAUD_DIV, default 217, clk_25mhz cycles per UART bit (115200 baud).
REQ-002 Parameter FETCH_LAT, default 2, cycles from sample_index_out change to valid sample_data_in.
REQ-003 Port clk_25mhz  input  1  sole clock, 25 MHz.
REQ-004 Port rst_in  input  1  synchronous, active-high reset.
REQ-005 Port start_in  input  1  single-cycle dump request.
REQ-006 Port wave_width_in  input  16  sample count to dump; latched at accepted start.
REQ-007 Port sample_data_in  input  16  sample at sample_index_out, FETCH_LAT cycles late.
REQ-008 Port sample_index_out  output  16  requested sample index.
REQ-009 Port busy_out  output  1  high from accepted start to dump completion.
REQ-010 Port done_out  output  1  single-cycle pulse at dump completion.
REQ-011 Port uart_tx  output  1  UART 8N1 serial line, idle high.

Function
REQ-012 FSM states: IDLE, HEADER, FETCH, SEND_HI, SEND_LO, NEXT, FINISH.
REQ-013 IDLE: start_in high -> latch wave_width_in into width register, clear index to 0, busy_out high next cycle; go to HEADER (macro defined) or FETCH.
REQ-014 start_in while busy_out high: ignored, no state change.
REQ-015 Latched width 0: no sample bytes; header, if compiled in, still sent; then FINISH.
REQ-016 FETCH: hold sample_index_out constant exactly FETCH_LAT cycles, then capture sample_data_in into a 16-bit holding register.
REQ-017 SEND_HI transmits holding[15:8]; SEND_LO transmits holding[7:0]; each state waits for byte serializer ready before issuing, and exits on issue.
REQ-018 NEXT: index+1 < width -> increment index, go FETCH; else FINISH. Compare in 17 bits; width 0xFFFF dumps indices 0..0xFFFE, no wrap.
REQ-019 FINISH: wait for serializer idle (last stop bit complete), pulse done_out one cycle, drop busy_out same cycle, return IDLE.
REQ-020 Serializer frame: start bit 0, data LSB first, stop bit 1; each bit exactly BAUD_DIV cycles; back-to-back bytes carry no extra idle bits.
REQ-021 sample_index_out holds last value in IDLE; changes only in IDLE-accept and NEXT.

Reset
REQ-022 rst_in high at any clock edge: state IDLE, sample_index_out 0, busy_out 0, done_out 0, uart_tx 1 next cycle, including mid-frame; byte in flight is abandoned.
REQ-023 start_in asserted same cycle as rst_in is ignored.

Configuration
REQ-024 Macro DUMP_HEADER_EN defined: HEADER state sends 0xA5, 0x5A, width[15:8], width[7:0] before first sample.
REQ-025 Macro DUMP_HEADER_EN undefined: HEADER state absent; IDLE goes directly to FETCH; stream is samples only.

Structure
REQ-026 Shared package debug_pkg holds FSM state enum, header byte constants 0xA5/0x5A, default BAUD_DIV and FETCH_LAT.
REQ-027 Sub-module uart_byte_tx: ports clk_25mhz, rst_in, data[7:0], valid, ready, tx; one byte per valid&ready handshake.

Verification
REQ-028 Width 3, samples 0x1234,0xABCD,0x00FF, no header -> bytes 12 34 AB CD 00 FF, one done_out pulse, busy_out 0 after.
REQ-029 DUMP_HEADER_EN, width 2 -> bytes A5 5A 00 02 then 4 sample bytes.
REQ-030 Width 0, no header -> no start bit on uart_tx; done_out within 3 cycles of start.
REQ-031 Second start_in mid-dump -> byte count unchanged, single done_out.
REQ-032 rst_in during bit 4 of second byte -> uart_tx 1 next cycle, busy_out 0; fresh start dumps correctly.
REQ-033 Measure bit cell -> exactly 217 cycles; frame 2170 cycles; consecutive start bits 2170 cycles apart.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and constants for the waveform dump sequencer.
// FSM state encoding, header bytes and default timing parameters.
package debug_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FETCH,
    S_SEND_HI,
    S_SEND_LO,
    S_NEXT,
    S_FINISH
  } state_e;

  localparam logic [7:0] HDR_BYTE0     = 8'hA5;
  localparam logic [7:0] HDR_BYTE1     = 8'h5A;
  localparam int         BAUD_DIV_DEF  = 217;
  localparam int         FETCH_LAT_DEF = 2;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer with a valid/ready byte handshake.
// ready rises in the last stop-bit cycle so frames can run back to back.
module uart_byte_tx
  import debug_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk_25mhz,
  input  logic       rst_in,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       idle,
  output logic       tx
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic [8:0]    sh_q, sh_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] baud_q, baud_d;
  logic          last_cyc;

  assign last_cyc = busy_q && (bit_q == 4'd9) && (baud_q == LAST);
  assign ready    = !busy_q || last_cyc;
  assign idle     = !busy_q;
  assign tx       = tx_q;

  // Bit timing: load a frame on handshake, otherwise step through start/data/stop.
  always_comb begin
    busy_d = busy_q;
    tx_d   = tx_q;
    sh_d   = sh_q;
    bit_d  = bit_q;
    baud_d = baud_q;
    if (valid && ready) begin
      busy_d = 1'b1;
      tx_d   = 1'b0;
      sh_d   = {1'b1, data};
      bit_d  = 4'd0;
      baud_d = '0;
    end else if (busy_q) begin
      if (baud_q == LAST) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          tx_d  = sh_q[0];
          sh_d  = {1'b1, sh_q[8:1]};
          bit_d = bit_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + CW'(1);
      end
    end
  end

  // Serializer registers; reset abandons any frame in flight.
  always_ff @(posedge clk_25mhz) begin
    if (rst_in) begin
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
      sh_q   <= '1;
      bit_q  <= '0;
      baud_q <= '0;
    end else begin
      busy_q <= busy_d;
      tx_q   <= tx_d;
      sh_q   <= sh_d;
      bit_q  <= bit_d;
      baud_q <= baud_d;
    end
  end

endmodule

// File: rtl/wave_dump_sequencer.sv
// Streams a captured waveform out over UART as big-endian 16-bit samples.
// Define DUMP_HEADER_EN to prefix the stream with A5 5A width_hi width_lo.
module wave_dump_sequencer
  import debug_pkg::*;
#(
  parameter int BAUD_DIV  = BAUD_DIV_DEF,
  parameter int FETCH_LAT = FETCH_LAT_DEF
) (
  input  logic        clk_25mhz,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic [15:0] wave_width_in,
  input  logic [15:0] sample_data_in,
  output logic [15:0] sample_index_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        uart_tx
);

  localparam int FCW = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
  localparam logic [FCW-1:0] FLAST = FCW'(FETCH_LAT - 1);

  state_e          state_q, state_d;
  logic [15:0]     width_q, width_d;
  logic [15:0]     index_q, index_d;
  logic [15:0]     hold_q, hold_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tx_valid, tx_ready, tx_idle;
  logic [7:0]      tx_data;
`ifdef DUMP_HEADER_EN
  logic [1:0]      hcnt_q, hcnt_d;
`endif

  assign sample_index_out = index_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;

  uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk_25mhz (clk_25mhz),
    .rst_in    (rst_in),
    .data      (tx_data),
    .valid     (tx_valid),
    .ready     (tx_ready),
    .idle      (tx_idle),
    .tx        (uart_tx)
  );

  // Next-state and byte-issue logic for the dump sequence.
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    index_d  = index_q;
    hold_d   = hold_q;
    fcnt_d   = fcnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
`ifdef DUMP_HEADER_EN
    hcnt_d   = hcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          width_d = wave_width_in;
          index_d = '0;
          fcnt_d  = '0;
          busy_d  = 1'b1;
`ifdef DUMP_HEADER_EN
          hcnt_d  = 2'd0;
          state_d = S_HEADER;
`else
          state_d = (wave_width_in == 16'd0) ? S_FINISH : S_FETCH;
`endif
        end
      end
`ifdef DUMP_HEADER_EN
      S_HEADER: begin
        tx_valid = 1'b1;
        case (hcnt_q)
          2'd0:    tx_data = HDR_BYTE0;
          2'd1:    tx_data = HDR_BYTE1;
          2'd2:    tx_data = width_q[15:8];
          default: tx_data = width_q[7:0];
        endcase
        if (tx_ready) begin
          hcnt_d = hcnt_q + 2'd1;
          if (hcnt_q == 2'd3) begin
            fcnt_d  = '0;
            state_d = (width_q == 16'd0) ? S_FINISH : S_FETCH;
          end
        end
      end
`endif
      S_FETCH: begin
        if (fcnt_q == FLAST) begin
          hold_d  = sample_data_in;
          state_d = S_SEND_HI;
        end else begin
          fcnt_d = fcnt_q + FCW'(1);
        end
      end
      S_SEND_HI: begin
        tx_valid = 1'b1;
        tx_data  = hold_q[15:8];
        if (tx_ready) state_d = S_SEND_LO;
      end
      S_SEND_LO: begin
        tx_valid = 1'b1;
        tx_data  = hold_q[7:0];
        if (tx_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (({1'b0, index_q} + 17'd1) < {1'b0, width_q}) begin
          index_d = index_q + 16'd1;
          fcnt_d  = '0;
          state_d = S_FETCH;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        if (tx_idle) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk_25mhz) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      width_q <= '0;
      index_q <= '0;
      hold_q  <= '0;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DUMP_HEADER_EN
      hcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      index_q <= index_d;
      hold_q  <= hold_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DUMP_HEADER_EN
      hcnt_q  <= hcnt_d;
`endif
    end
  end

endmodule
